identify_issue_ctrl: RTL and testbench
======================================

Name: identify_issue_ctrl

Overview:
Sequencer in front of the Identify decode stage. Accepts 32-bit instruction words from fetch over a valid/ready handshake, buffers them, and assembles POWER v3.1 prefixed instructions (prefix word, primary opcode 1, followed by suffix word) into 64-bit units. Presents one complete instruction at a time to Identify on o_id_en/o_id_instr, and holds it until the selected execution unit accepts it. Flush discards all buffered words on a branch redirect.

Parameters:
DEPTH, 4, word buffer entries (power of two, >=2)
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  discard all buffered words and the in-flight instruction
i_fetch_valid  in  1  fetch word valid
i_fetch_word  in  [0:31]  instruction word, bit 0 = MSB (ISA numbering)
o_fetch_ready  out  1  buffer can accept a word
o_id_en  out  1  enable to Identify: complete instruction presented
o_id_instr  out  [0:63]  to Identify i_instr; {prefix,suffix} or {word,32'b0}
i_id_bu_en  in  1  Identify o_bu_en, combinational same cycle
i_bu_ready  in  1  branch unit accepts
i_other_ready  in  1  non-branch path accepts
o_issue_fire  out  1  instruction accepted this cycle
o_prefix_err  out  1  one-cycle pulse: prefix followed by prefix
o_occupancy  out  CNT_W  buffered word count

Behaviour:
- Reset (async assert, sync release): buffer empty, state EMPTY, o_occupancy=0, o_id_en=0, o_id_instr=0, o_issue_fire=0, o_prefix_err=0, o_fetch_ready=1.
- Push = i_fetch_valid & o_fetch_ready; o_fetch_ready = (occupancy<DEPTH) | fire (pop frees space same cycle) and is 0 when i_flush=1.
- Word pushed at edge N is visible at head from cycle N+1; no bypass.
- Head prefix test: head[0:5]==6'd1.
- States (registered, next-state from post-edge buffer content):
  EMPTY: occupancy==0. o_id_en=0.
  WAIT_SUFFIX: head is prefix, occupancy==1. o_id_en=0.
  READY: head non-prefix, or head prefix with occupancy>=2. o_id_en=1 (except prefix-error case).
- o_id_instr in READY: non-prefix {head,32'b0}; prefix {head,head+1}. Is 0 when o_id_en=0.
- Fire = o_id_en & (i_id_bu_en ? i_bu_ready : i_other_ready). o_issue_fire = fire, combinational. Pops 1 word (non-prefix) or 2 (prefix).
- o_id_instr and o_id_en stay stable until fire; ready may toggle freely.
- Prefix error: head prefix and head+1 also prefix -> o_id_en=0, o_prefix_err=1 for one cycle, pop the first prefix only; the second word becomes head next cycle.
- Push and pop in same cycle: occupancy += 1 - popcount; full buffer with fire accepts the push.
- Flush: takes priority over push and pop; next edge occupancy=0, state EMPTY; o_issue_fire forced 0 in flush cycle.
- Pointers wrap modulo DEPTH; a prefix/suffix pair may straddle the wrap.
- Reset mid-operation drops all contents immediately; no partial instruction survives.

Decomposition:
- Package id_pkg: PREFIX_OPCODE=6'd1, instruction-word typedef [0:31], 64-bit instruction typedef, state enum {EMPTY, WAIT_SUFFIX, READY}.
- Sub-module id_word_fifo: circular buffer with 1-push/2-pop ports, exposing head, head+1 and count. Controller FSM and issue logic stay in identify_issue_ctrl.

Test Plan:
- Push 32'h48032BFB, i_id_bu_en=1, i_bu_ready=1 -> cycle after push o_id_en=1, o_id_instr={32'h48032BFB,32'h0}, o_issue_fire=1, occupancy back to 0.
- Push prefix 32'h04000000, wait 3 cycles, then push 32'h38600001 -> WAIT_SUFFIX while alone (o_id_en=0). One cycle after suffix push: o_id_instr=64'h04000000_38600001, fires with i_other_ready=1, pops 2.
- Fill DEPTH=4 with non-prefix words, all readies 0 -> o_fetch_ready=0, occupancy=4, o_id_instr stable 4 cycles. Raise i_other_ready with a pending push -> fire and push same edge, occupancy stays 4.
- Push 32'h04000000 twice, then a non-prefix word -> single o_prefix_err pulse, no fire. Second prefix pairs with the third word and issues as 64-bit.
- With 3 words buffered and i_fetch_valid=1, assert i_flush -> no fire, push dropped, next cycle occupancy=0, state EMPTY.
- Prefix/suffix placed at entries 3/0 (after wrap) -> assembled correctly. Assert i_rst_n=0 mid-hold -> o_id_en drops to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types for the Identify issue sequencer: word/instruction types,
// controller states and the prefix-opcode test.
package id_pkg;

    localparam logic [5:0] PREFIX_OPCODE = 6'd1;

    // ISA bit numbering: bit 0 is the MSB
    typedef logic [0:31] word_t;
    typedef logic [0:63] instr_t;

    typedef enum logic [1:0] {
        EMPTY,
        WAIT_SUFFIX,
        READY
    } state_e;

    // Primary opcode 1 marks the prefix word of a 64-bit instruction
    function automatic logic is_prefix(input word_t w);
        return w[0:5] == PREFIX_OPCODE;
    endfunction

endpackage

// File: rtl/id_word_fifo.sv
// Circular word buffer: one push and up to two pops per cycle. Exposes the
// head, the word behind it, and a look-ahead of the head/count after the
// next edge so the controller can register its state from post-edge content.
module id_word_fifo
    import id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  word_t            wdata,
    input  logic [1:0]       pop,
    output word_t            head,
    output word_t            head1,
    output word_t            nxt_head,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] nxt_cnt
);

    localparam int PW = $clog2(DEPTH);

    word_t         mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] nxt_rd;
    logic          wr_en;

    assign wr_en  = push && !flush;
    assign head   = mem[rd_ptr];
    assign head1  = mem[rd_ptr + PW'(1)];
    // Flush empties the buffer by catching the read pointer up to the writer
    assign nxt_rd = flush ? wr_ptr : rd_ptr + PW'(pop);

    // Post-edge view: count, and head including a word written this edge
    always_comb begin
        nxt_cnt  = flush ? '0 : cnt + CNT_W'(wr_en) - CNT_W'(pop);
        nxt_head = (wr_en && (wr_ptr == nxt_rd)) ? wdata : mem[nxt_rd];
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= nxt_rd;
            cnt    <= nxt_cnt;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // Storage needs no reset: entries are only read when counted as valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/identify_issue_ctrl.sv
// Issue sequencer ahead of Identify: buffers fetched words, pairs prefix and
// suffix into 64-bit instructions and holds each one until its unit accepts.
module identify_issue_ctrl
    import id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_fetch_valid,
    input  logic [0:31]      i_fetch_word,
    output logic             o_fetch_ready,
    output logic             o_id_en,
    output logic [0:63]      o_id_instr,
    input  logic             i_id_bu_en,
    input  logic             i_bu_ready,
    input  logic             i_other_ready,
    output logic             o_issue_fire,
    output logic             o_prefix_err,
    output logic [CNT_W-1:0] o_occupancy
);

    state_e           state;
    state_e           nxt_state;
    word_t            head;
    word_t            head1;
    word_t            nxt_head;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [1:0]       pop;
    logic             push;
    logic             head_pfx;
    logic             pair_err;

    id_word_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .push     (push),
        .wdata    (i_fetch_word),
        .pop      (pop),
        .head     (head),
        .head1    (head1),
        .nxt_head (nxt_head),
        .cnt      (cnt),
        .nxt_cnt  (nxt_cnt)
    );

    assign head_pfx    = is_prefix(head);
    // READY with a prefix head implies two words are buffered, so head1 is valid
    assign pair_err    = (state == READY) && head_pfx && is_prefix(head1);
    assign o_occupancy = cnt;

    // Issue path: present instruction, decide fire, pop count and back-pressure
    always_comb begin
        o_id_en      = (state == READY) && !pair_err;
        o_id_instr   = '0;
        if (o_id_en) o_id_instr = head_pfx ? {head, head1} : {head, 32'h0};
        o_issue_fire = o_id_en && !i_flush && (i_id_bu_en ? i_bu_ready : i_other_ready);
        o_prefix_err = pair_err && !i_flush;
        pop          = 2'd0;
        if (o_issue_fire)      pop = head_pfx ? 2'd2 : 2'd1;
        else if (o_prefix_err) pop = 2'd1;  // drop the orphan prefix only
        // A pop in the same cycle frees a slot for the incoming word
        o_fetch_ready = !i_flush && ((cnt < CNT_W'(DEPTH)) || o_issue_fire);
        push          = i_fetch_valid && o_fetch_ready;
    end

    // Next state follows the buffer content as it will be after this edge
    always_comb begin
        nxt_state = EMPTY;
        if (nxt_cnt == '0)                                   nxt_state = EMPTY;
        else if (is_prefix(nxt_head) && nxt_cnt == CNT_W'(1)) nxt_state = WAIT_SUFFIX;
        else                                                 nxt_state = READY;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= EMPTY;
        else          state <= nxt_state;
    end

endmodule

// File: tb/tb_identify_issue_ctrl.sv
// Self-checking bench for identify_issue_ctrl: expected instructions go into
// a scoreboard when driven and are compared whenever the DUT fires.
module tb_identify_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             fvalid = 1'b0;
    logic [0:31]      fword = '0;
    logic             fready;
    logic             id_en;
    logic [0:63]      id_instr;
    logic             bu_en = 1'b0;
    logic             bu_ready = 1'b0;
    logic             other_ready = 1'b0;
    logic             fire;
    logic             perr;
    logic [CNT_W-1:0] occ;

    int               n_chk = 0;
    int               n_pass = 0;
    int               n_perr = 0;
    logic [63:0]      sb[$];

    identify_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_fetch_valid (fvalid),
        .i_fetch_word  (fword),
        .o_fetch_ready (fready),
        .o_id_en       (id_en),
        .o_id_instr    (id_instr),
        .i_id_bu_en    (bu_en),
        .i_bu_ready    (bu_ready),
        .i_other_ready (other_ready),
        .o_issue_fire  (fire),
        .o_prefix_err  (perr),
        .o_occupancy   (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard compare on every accepted instruction
    always @(negedge clk) begin
        if (rst_n && fire) begin
            if (sb.size() == 0) chk("issue_unexpected", 64'd1, 64'd0);
            else                chk("issue", id_instr, sb.pop_front());
        end
        if (rst_n && perr) n_perr++;
    end

    // Inputs change just after the rising edge; outputs sampled on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fvalid = 1'b1;
        fword  = w;
        step();
        fvalid = 1'b0;
    endtask

    task automatic drain();
        other_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (occ == 0) break;
            step();
        end
        chk("drain_occ", 64'(occ), 64'd0);
        step();
        other_ready = 1'b0;
    endtask

    localparam logic [31:0] W1 = 32'h48032BFB;
    localparam logic [31:0] P  = 32'h04000000;
    localparam logic [31:0] S  = 32'h38600001;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_id_en", 64'(id_en), 64'd0);
        chk("rst_instr", id_instr, 64'd0);
        chk("rst_fire", 64'(fire), 64'd0);
        chk("rst_perr", 64'(perr), 64'd0);
        chk("rst_fready", 64'(fready), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single non-prefix word via the branch unit
        bu_en = 1'b1; bu_ready = 1'b1;
        sb.push_back({W1, 32'h0});
        push(W1);
        @(negedge clk);
        chk("t1_id_en", 64'(id_en), 64'd1);
        chk("t1_fire", 64'(fire), 64'd1);
        step();
        bu_en = 1'b0; bu_ready = 1'b0;
        @(negedge clk);
        chk("t1_occ", 64'(occ), 64'd0);
        chk("t1_id_en_after", 64'(id_en), 64'd0);
        step();

        // Prefix alone waits for its suffix
        push(P);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wait_en", 64'(id_en), 64'd0);
            chk("t2_wait_occ", 64'(occ), 64'd1);
            step();
        end
        other_ready = 1'b1;
        sb.push_back({P, S});
        push(S);
        @(negedge clk);
        chk("t2_instr", id_instr, 64'h04000000_38600001);
        chk("t2_fire", 64'(fire), 64'd1);
        chk("t2_occ", 64'(occ), 64'd2);
        step();
        other_ready = 1'b0;
        @(negedge clk);
        chk("t2_occ_after", 64'(occ), 64'd0);
        step();

        // Fill to full, hold, then fire and push on the same edge
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back({32'h38600010 + 32'(i), 32'h0});
            push(32'h38600010 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_fready", 64'(fready), 64'd0);
            chk("t3_occ", 64'(occ), 64'd4);
            chk("t3_hold", id_instr, {32'h38600010, 32'h0});
            step();
        end
        fvalid = 1'b1; fword = 32'h38600020; other_ready = 1'b1;
        sb.push_back({32'h38600020, 32'h0});
        @(negedge clk);
        chk("t3_fready_fire", 64'(fready), 64'd1);
        chk("t3_fire", 64'(fire), 64'd1);
        step();
        fvalid = 1'b0; other_ready = 1'b0;
        @(negedge clk);
        chk("t3_occ_full", 64'(occ), 64'd4);
        chk("t3_next", id_instr, {32'h38600011, 32'h0});
        step();
        drain();

        // Prefix followed by prefix: one error pulse, second pairs with third
        other_ready = 1'b1;
        push(P);
        push(P);
        fvalid = 1'b1; fword = S;
        sb.push_back({P, S});
        @(negedge clk);
        chk("t4_perr", 64'(perr), 64'd1);
        chk("t4_no_fire", 64'(fire), 64'd0);
        chk("t4_en", 64'(id_en), 64'd0);
        step();
        fvalid = 1'b0;
        @(negedge clk);
        chk("t4_perr_clr", 64'(perr), 64'd0);
        chk("t4_pair", id_instr, 64'h04000000_38600001);
        chk("t4_fire", 64'(fire), 64'd1);
        step();
        other_ready = 1'b0;
        @(negedge clk);
        chk("t4_occ", 64'(occ), 64'd0);
        chk("t4_perr_count", 64'(n_perr), 64'd1);
        step();

        // Flush with three buffered words and a pending push
        for (int i = 0; i < 3; i++) push(32'h38600030 + 32'(i));
        fvalid = 1'b1; fword = 32'h38600040; flush = 1'b1; other_ready = 1'b1;
        @(negedge clk);
        chk("t5_fire", 64'(fire), 64'd0);
        chk("t5_fready", 64'(fready), 64'd0);
        step();
        fvalid = 1'b0; flush = 1'b0; other_ready = 1'b0;
        @(negedge clk);
        chk("t5_occ", 64'(occ), 64'd0);
        chk("t5_en", 64'(id_en), 64'd0);
        step();

        // 14 words have been written so far, so the next write lands in entry 2:
        // a filler there puts the prefix in entry 3 and its suffix in entry 0.
        other_ready = 1'b1;
        sb.push_back({32'h38600050, 32'h0});
        push(32'h38600050);
        sb.push_back(64'h04000012_38600002);
        push(32'h04000012);
        @(negedge clk);
        chk("t6_wait", 64'(id_en), 64'd0);
        step();
        push(32'h38600002);
        @(negedge clk);
        chk("t6_wrap", id_instr, 64'h04000012_38600002);
        step();
        other_ready = 1'b0;

        // Asynchronous reset while an instruction is held
        push(32'h38600060);
        @(negedge clk);
        chk("t7_held", 64'(id_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_en", 64'(id_en), 64'd0);
        chk("t7_async_occ", 64'(occ), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("t7_post_en", 64'(id_en), 64'd0);
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
